// File: rtl/mem_stage_if.sv
// Signal bundle of the memory stage: execute handshake, data-memory bus and
// writeback result. The stage itself connects through the master modport;
// the surrounding pipeline/memory environment uses the slave modport.
interface mem_stage_if;
    // execute -> memory stage
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] ex_alu_i;
    logic [31:0] ex_store_data_i;
    logic [4:0]  ex_rd_i;
    logic [2:0]  ex_funct3_i;
    logic        ex_load_i;
    logic        ex_store_i;
    logic        ex_wb_en_i;
    // memory stage <-> data memory
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    // memory stage -> writeback
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misaligned_o;
    logic        bus_err_o;

    modport master (
        input  ex_valid_i, ex_alu_i, ex_store_data_i, ex_rd_i, ex_funct3_i,
               ex_load_i, ex_store_i, ex_wb_en_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output ex_ready_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
               wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misaligned_o, bus_err_o
    );

    modport slave (
        output ex_valid_i, ex_alu_i, ex_store_data_i, ex_rd_i, ex_funct3_i,
               ex_load_i, ex_store_i, ex_wb_en_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  ex_ready_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
               wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misaligned_o, bus_err_o
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: passes ALU results through, runs one
// request/grant/response data-memory transaction per load/store, aligns and
// extends load data, flags misaligned/illegal accesses and bounds every
// transaction with a timeout. The writeback bundle is registered.
module mem_stage #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mem_stage_if.master bus
);
    localparam int unsigned      CNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Width code / alignment legality; stores only have 000/001/010.
    function automatic logic f_legal(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = (off[0] == 1'b0);
            3'b010:         ok = (off == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok & ~(ld & st) & ~(st & f3[2]);
    endfunction

    // Byte enables: loads always read the whole word.
    function automatic logic [3:0] f_be(input logic ld, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic [3:0] be;
        if (ld) begin
            be = 4'b1111;
        end else begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << off;
                2'b01:   be = 4'b0011 << {off[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Store data replicated across all lanes so the byte enables pick the lane.
    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             is_mem_s, legal_s;
    logic             accept_s, mem_go_s, fault_s, done_s, timeout_s;

    logic             load_r;
    logic [2:0]       funct3_r;
    logic [1:0]       off_r;
    logic [4:0]       rd_r;
    logic             dmem_we_r;
    logic [31:0]      dmem_addr_r;
    logic [3:0]       dmem_be_r;
    logic [31:0]      dmem_wdata_r;
    logic             wb_valid_r, wb_we_r, misaligned_r, bus_err_r;
    logic [4:0]       wb_rd_r;
    logic [31:0]      wb_data_r;

    assign is_mem_s = bus.ex_load_i | bus.ex_store_i;
    assign legal_s  = f_legal(bus.ex_load_i, bus.ex_store_i, bus.ex_funct3_i, bus.ex_alu_i[1:0]);

    // Next-state and event decode for the IDLE/REQ/WAIT transaction FSM.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        mem_go_s    = 1'b0;
        fault_s     = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.ex_valid_i) begin
                    accept_s = 1'b1;
                    if (!is_mem_s) begin
                        state_nxt_s = S_IDLE;
                    end else if (legal_s) begin
                        mem_go_s    = 1'b1;
                        state_nxt_s = S_REQ;
                    end else begin
                        fault_s     = 1'b1;
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (cnt_r == CNT_MAX) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = S_IDLE;
                end else if (bus.dmem_gnt_i) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                // A response in the timeout cycle still completes normally.
                if (bus.dmem_rvalid_i) begin
                    done_s      = 1'b1;
                    state_nxt_s = S_IDLE;
                end else if (cnt_r == CNT_MAX) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Transaction timeout counter: cleared on entering REQ, counts in REQ/WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (mem_go_s || done_s || timeout_s) begin
            cnt_r <= '0;
        end else if (state_r != S_IDLE) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Latch the accepted memory op and produce the one-cycle writeback bundle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_r       <= 1'b0;
            funct3_r     <= 3'd0;
            off_r        <= 2'd0;
            rd_r         <= 5'd0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'd0;
            dmem_be_r    <= 4'd0;
            dmem_wdata_r <= 32'd0;
            wb_valid_r   <= 1'b0;
            wb_we_r      <= 1'b0;
            wb_rd_r      <= 5'd0;
            wb_data_r    <= 32'd0;
            misaligned_r <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            wb_valid_r   <= 1'b0;
            wb_we_r      <= 1'b0;
            misaligned_r <= 1'b0;
            bus_err_r    <= 1'b0;
            if (accept_s && !is_mem_s) begin
                wb_valid_r <= 1'b1;
                wb_we_r    <= bus.ex_wb_en_i & (bus.ex_rd_i != 5'd0);
                wb_rd_r    <= bus.ex_rd_i;
                wb_data_r  <= bus.ex_alu_i;
            end else if (fault_s) begin
                wb_valid_r   <= 1'b1;
                misaligned_r <= 1'b1;
                wb_rd_r      <= bus.ex_rd_i;
                wb_data_r    <= bus.ex_alu_i;
            end else if (mem_go_s) begin
                load_r       <= bus.ex_load_i;
                funct3_r     <= bus.ex_funct3_i;
                off_r        <= bus.ex_alu_i[1:0];
                rd_r         <= bus.ex_rd_i;
                dmem_we_r    <= bus.ex_store_i;
                dmem_addr_r  <= {bus.ex_alu_i[31:2], 2'b00};
                dmem_be_r    <= f_be(bus.ex_load_i, bus.ex_funct3_i, bus.ex_alu_i[1:0]);
                dmem_wdata_r <= f_wdata(bus.ex_funct3_i, bus.ex_store_data_i);
            end else if (done_s) begin
                wb_valid_r <= 1'b1;
                wb_we_r    <= load_r & (rd_r != 5'd0);
                wb_rd_r    <= rd_r;
                wb_data_r  <= load_r ? f_load(funct3_r, off_r, bus.dmem_rdata_i) : 32'd0;
            end else if (timeout_s) begin
                wb_valid_r <= 1'b1;
                bus_err_r  <= 1'b1;
                wb_rd_r    <= rd_r;
                wb_data_r  <= 32'd0;
            end else begin
                wb_rd_r    <= wb_rd_r;
                wb_data_r  <= wb_data_r;
            end
        end
    end

    assign bus.ex_ready_o   = (state_r == S_IDLE);
    assign bus.dmem_req_o   = (state_r == S_REQ);
    assign bus.dmem_we_o    = dmem_we_r;
    assign bus.dmem_addr_o  = dmem_addr_r;
    assign bus.dmem_be_o    = dmem_be_r;
    assign bus.dmem_wdata_o = dmem_wdata_r;
    assign bus.wb_valid_o   = wb_valid_r;
    assign bus.wb_we_o      = wb_we_r;
    assign bus.wb_rd_o      = wb_rd_r;
    assign bus.wb_data_o    = wb_data_r;
    assign bus.misaligned_o = misaligned_r;
    assign bus.bus_err_o    = bus_err_r;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed and random operations, a
// data-memory responder with programmable grant/response delays, and a
// scoreboard monitor comparing every writeback against a reference model.
module tb_mem_stage;
    localparam int WAIT_MAX = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_stage_if bus();

    mem_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // responder configuration, set per operation by the driver
    int          gnt_dly = 0, rv_dly = 0, req_wait_cnt = 0, rv_cnt = 0;
    bit          rv_never = 1'b0, rv_pending = 1'b0;
    logic [31:0] rdata_v = 32'd0, exp_addr = 32'd0, exp_wdata = 32'd0;
    logic [3:0]  exp_be = 4'd0;
    logic        exp_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input logic ld, input logic st,
                                       input logic [2:0] f3, input logic [31:0] addr);
        if (ld && st) return 1'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (st && f3 >= 3'd4) return 1'b0;
        return (addr % op_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint unsigned raw;
        longint unsigned full;
        int size;
        int off;
        size = op_size(f3);
        off  = addr % 4;
        full = 64'd1 << (8 * size);
        raw  = rdata;
        raw  = (raw >> (8 * off)) % full;
        if (f3 < 3'd4 && size < 4 && raw >= (full >> 1)) raw = raw - full;
        return raw[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << op_size(f3)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (op_size(f3))
            1:       return (d & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_i) begin
        if (bus.wb_valid_o || bus.misaligned_o || bus.bus_err_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_cycle", cyc, mon_e.cyc);
                check("wb_valid", bus.wb_valid_o, 1'b1);
                check("wb_we", bus.wb_we_o, mon_e.we);
                if (mon_e.we) check("wb_rd", bus.wb_rd_o, mon_e.rd);
                if (mon_e.chk_data) check("wb_data", bus.wb_data_o, mon_e.data);
                check("misaligned", bus.misaligned_o, mon_e.mis);
                check("bus_err", bus.bus_err_o, mon_e.berr);
                check("ready_at_wb", bus.ex_ready_o, 1'b1);
            end
        end
    end

    // ---------------- data memory responder ----------------
    initial begin : dmem_model
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = 32'd0;
        forever begin
            @(negedge clk_i);
            bus.dmem_gnt_i    = 1'b0;
            bus.dmem_rvalid_i = 1'b0;
            if (bus.dmem_req_o && !rst_i) begin
                check("req_addr", bus.dmem_addr_o, exp_addr);
                check("req_we", bus.dmem_we_o, exp_we);
                check("req_be", bus.dmem_be_o, exp_be);
                if (exp_we) check("req_wdata", bus.dmem_wdata_o, exp_wdata);
                if (req_wait_cnt == gnt_dly) begin
                    bus.dmem_gnt_i = 1'b1;
                    req_wait_cnt   = 0;
                    rv_pending     = 1'b1;
                    rv_cnt         = 0;
                end else begin
                    req_wait_cnt++;
                end
            end else if (rv_pending) begin
                if (!rv_never && rv_cnt == rv_dly) begin
                    bus.dmem_rvalid_i = 1'b1;
                    bus.dmem_rdata_i  = rdata_v;
                    rv_pending        = 1'b0;
                end else begin
                    rv_cnt++;
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; presents one op when ready, returns one cycle later.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic wben, input int gd, input int rv, input bit never,
                         input logic [31:0] rdata, input bit expect_out);
        int   guard;
        int   total;
        bit   legal;
        exp_t e;
        guard = 0;
        while (!bus.ex_ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (!bus.ex_ready_o) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        legal      = model_legal(ld, st, f3, alu);
        e.rd       = rd;
        e.data     = 32'd0;
        e.chk_data = 1'b0;
        e.we       = 1'b0;
        e.mis      = 1'b0;
        e.berr     = 1'b0;
        if (!(ld || st)) begin
            e.cyc      = cyc + 1;
            e.we       = wben && (rd != 5'd0);
            e.data     = alu;
            e.chk_data = 1'b1;
        end else if (!legal) begin
            e.cyc = cyc + 1;
            e.mis = 1'b1;
        end else begin
            total = 1 + gd + rv;
            if (never || total > WAIT_MAX) begin
                e.cyc  = cyc + WAIT_MAX + 2;
                e.berr = 1'b1;
            end else begin
                e.cyc      = cyc + 2 + total;
                e.we       = ld && (rd != 5'd0);
                e.data     = model_load(f3, alu, rdata);
                e.chk_data = ld;
            end
        end
        gnt_dly      = gd;
        rv_dly       = rv;
        rv_never     = never;
        rdata_v      = rdata;
        req_wait_cnt = 0;
        rv_pending   = 1'b0;
        rv_cnt       = 0;
        exp_addr     = alu & 32'hFFFF_FFFC;
        exp_we       = st;
        exp_be       = ld ? 4'hF : model_be(f3, alu);
        exp_wdata    = model_wdata(f3, sd);
        if (expect_out) exp_q.push_back(e);
        bus.ex_load_i       = ld;
        bus.ex_store_i      = st;
        bus.ex_funct3_i     = f3;
        bus.ex_alu_i        = alu;
        bus.ex_store_data_i = sd;
        bus.ex_rd_i         = rd;
        bus.ex_wb_en_i      = wben;
        bus.ex_valid_i      = 1'b1;
        @(negedge clk_i);
        bus.ex_valid_i = 1'b0;
        if ((ld || st) && !legal) check("fault_no_req", bus.dmem_req_o, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [2:0]  f3;
        int          k;
        bus.ex_valid_i      = 1'b0;
        bus.ex_load_i       = 1'b0;
        bus.ex_store_i      = 1'b0;
        bus.ex_funct3_i     = 3'd0;
        bus.ex_alu_i        = 32'd0;
        bus.ex_store_data_i = 32'd0;
        bus.ex_rd_i         = 5'd0;
        bus.ex_wb_en_i      = 1'b0;

        // reset state
        repeat (2) @(negedge clk_i);
        check("rst_ready", bus.ex_ready_o, 1'b1);
        check("rst_req", bus.dmem_req_o, 1'b0);
        check("rst_be", bus.dmem_be_o, 4'd0);
        check("rst_wb_valid", bus.wb_valid_o, 1'b0);
        check("rst_wb_data", bus.wb_data_o, 32'd0);
        check("rst_mis", bus.misaligned_o, 1'b0);
        check("rst_berr", bus.bus_err_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // ALU pass-through, back to back, rd=5 then rd=0
        issue(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 0, 0, 1'b0, 32'd0, 1'b1);
        issue(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'd0, 5'd0, 1'b1, 0, 0, 1'b0, 32'd0, 1'b1);
        // LB / LBU at 0x103, minimum latency
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd9, 1'b1, 0, 0, 1'b0, 32'h80AA_BBCC, 1'b1);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 5'd9, 1'b1, 0, 0, 1'b0, 32'h80AA_BBCC, 1'b1);
        // SH at 0x202 with a two-cycle grant delay
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1'b1, 2, 1, 1'b0, 32'd0, 1'b1);
        // misaligned LW and illegal funct3
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 5'd4, 1'b1, 0, 0, 1'b0, 32'd0, 1'b1);
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 5'd4, 1'b1, 0, 0, 1'b0, 32'd0, 1'b1);
        // timeout with grant but no response, then a normal ALU op
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 5'd6, 1'b1, 0, 0, 1'b1, 32'd0, 1'b1);
        issue(1'b0, 1'b0, 3'd0, 32'hCAFE_0001, 32'd0, 5'd7, 1'b1, 0, 0, 1'b0, 32'd0, 1'b1);
        // timeout boundary: response exactly at the limit wins, one later times out
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0502, 32'd0, 5'd8, 1'b1, 0, WAIT_MAX - 1, 1'b0, 32'h8001_7FFF, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'd0, 5'd8, 1'b1, WAIT_MAX - 1, 0, 1'b0, 32'h1357_9BDF, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0508, 32'd0, 5'd8, 1'b1, 0, WAIT_MAX, 1'b0, 32'h1111_2222, 1'b1);
        // grant never given: timeout while still requesting
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'h5555_AAAA, 5'd1, 1'b1, 100, 0, 1'b0, 32'd0, 1'b1);
        drain();

        // reset while in WAIT: everything clears at once, late rvalid ignored
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 5'd7, 1'b1, 0, 5, 1'b0, 32'h1234_5678, 1'b0);
        @(negedge clk_i);
        check("in_wait_busy", bus.ex_ready_o, 1'b0);
        #1 rst_i = 1'b1;
        #1;
        check("rst_wait_req", bus.dmem_req_o, 1'b0);
        check("rst_wait_wb_valid", bus.wb_valid_o, 1'b0);
        check("rst_wait_cnt", dut.cnt_r, 32'd0);
        check("rst_wait_ready", bus.ex_ready_o, 1'b1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check("post_rst_ready", bus.ex_ready_o, 1'b1);

        // reset while requesting: dmem_req_o drops before the next clock edge
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0701, 32'h0000_00A5, 5'd2, 1'b1, 100, 0, 1'b0, 32'd0, 1'b0);
        check("in_req", bus.dmem_req_o, 1'b1);
        #1 rst_i = 1'b1;
        #1;
        check("rst_req_drop", bus.dmem_req_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst2_ready", bus.ex_ready_o, 1'b1);
        issue(1'b0, 1'b0, 3'd0, 32'h0BAD_F00D, 32'd0, 5'd31, 1'b1, 0, 0, 1'b0, 32'd0, 1'b1);

        // randomized operations
        for (int i = 0; i < 200; i++) begin
            k  = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h0000_1000 + 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if (k <= 2) begin
                issue(1'b0, 1'b0, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 0, 0, 1'b0, 32'd0, 1'b1);
            end else begin
                issue(k <= 5 || k == 9, k >= 6, f3, a, $urandom, 5'($urandom_range(0, 31)),
                      1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 19) == 0), $urandom, 1'b1);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
